// File: rtl/frame_config_sequencer_if.sv
// frame_config_sequencer_if: bitstream word stream handshake between source and sequencer
interface frame_config_sequencer_if #(parameter int W = 32);
  logic [W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: parses sync/header/row words into per-row loads and one-hot frame strobes
module frame_config_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfRows = 16,
  parameter int ColSelWidth = 5,
  parameter logic [31:0] SyncWord = 32'hFAB0_FAB1
) (
  input  logic CLK,
  input  logic reset,
  frame_config_sequencer_if.slave s,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [NumberOfRows-1:0] RowWE,
  output logic [ColSelWidth-1:0] ColSelect,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic active,
  output logic err,
  output logic [15:0] frames_done
);
  localparam int RW = $clog2(NumberOfRows);
  localparam int FW = $clog2(MaxFramesPerCol);
  localparam logic [7:0] MAX_F = 8'(MaxFramesPerCol);
  localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, DATA = 3'd2, STROBE = 3'd3, GAP = 3'd4;
  logic [2:0] state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [ColSelWidth-1:0] col_q, col_d, col_sel_q, col_sel_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
  logic [NumberOfRows-1:0] row_we_q, row_we_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic active_q, active_d, err_q, err_d;
  logic [15:0] frames_done_q, frames_done_d;
  logic acc;
  assign s.in_ready = state_q == IDLE || state_q == HDR || state_q == DATA;
  assign acc = s.in_valid && s.in_ready;
  always_comb begin
    state_d = state_q;
    row_cnt_d = row_cnt_q;
    col_d = col_q;
    frame_d = frame_q;
    err_d = err_q;
    frame_data_d = frame_data_q;
    row_we_d = '0;
    col_sel_d = '0;
    strobe_d = '0;
    frames_done_d = frames_done_q;
    case (state_q)
      IDLE: state_d = (acc && s.in_data == SyncWord) ? HDR : IDLE;
      HDR: if (acc) begin
        if (s.in_data[15]) state_d = IDLE;
        else if (s.in_data[23:16] >= MAX_F) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else begin
          col_d = s.in_data[24 +: ColSelWidth];
          frame_d = s.in_data[16 +: FW];
          row_cnt_d = '0;
          state_d = DATA;
        end
      end
      DATA: if (acc) begin
        frame_data_d = s.in_data;
        row_we_d = NumberOfRows'(1) << row_cnt_q;
        row_cnt_d = row_cnt_q + 1'b1;
        state_d = (row_cnt_q == RW'(NumberOfRows - 1)) ? STROBE : DATA;
      end
      STROBE: begin
        strobe_d = MaxFramesPerCol'(1) << frame_q;
        col_sel_d = col_q;
        frames_done_d = frames_done_q + 16'd1;
        state_d = GAP;
      end
      GAP: state_d = HDR;
      default: state_d = IDLE;
    endcase
    active_d = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      row_cnt_q <= '0;
      col_q <= '0;
      frame_q <= '0;
      err_q <= 1'b0;
      frame_data_q <= '0;
      row_we_q <= '0;
      col_sel_q <= '0;
      strobe_q <= '0;
      frames_done_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_cnt_q <= row_cnt_d;
      col_q <= col_d;
      frame_q <= frame_d;
      err_q <= err_d;
      frame_data_q <= frame_data_d;
      row_we_q <= row_we_d;
      col_sel_q <= col_sel_d;
      strobe_q <= strobe_d;
      frames_done_q <= frames_done_d;
      active_q <= active_d;
    end
  end
  assign FrameData = frame_data_q;
  assign RowWE = row_we_q;
  assign ColSelect = col_sel_q;
  assign FrameStrobe = strobe_q;
  assign active = active_q;
  assign err = err_q;
  assign frames_done = frames_done_q;
endmodule

// File: tb/tb_frame_config_sequencer.sv
// tb_frame_config_sequencer: randomized stream stimulus with a queue-based frame model and decoupled monitor
module tb_frame_config_sequencer;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic [31:0] FrameData;
  logic [15:0] RowWE;
  logic [4:0] ColSelect;
  logic [19:0] FrameStrobe;
  logic active, err;
  logic [15:0] frames_done;
  frame_config_sequencer_if #(.W(32)) bus();
  frame_config_sequencer dut (
    .CLK(CLK), .reset(reset), .s(bus),
    .FrameData(FrameData), .RowWE(RowWE), .ColSelect(ColSelect),
    .FrameStrobe(FrameStrobe), .active(active), .err(err), .frames_done(frames_done)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    bit strb;
    logic [31:0] data;
    int idx;
    int col;
    int frm;
    int fd;
    bit er;
  } ev_t;
  ev_t q[$];
  int compared = 0;
  int mismatched = 0;
  int m_mode = 0;
  int m_row = 0;
  int m_col = 0;
  int m_frm = 0;
  int m_fd = 0;
  bit m_err = 0;
  logic [31:0] exp_fd = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model(input logic [31:0] w);
    ev_t e;
    if (m_mode == 0) begin
      if (w == SYNC) m_mode = 1;
    end else if (m_mode == 1) begin
      if (w[15]) m_mode = 0;
      else if (int'(w[23:16]) >= 20) begin
        m_err = 1;
        m_mode = 0;
      end else begin
        m_col = int'(w[28:24]);
        m_frm = int'(w[23:16]);
        m_row = 0;
        m_mode = 2;
      end
    end else begin
      e = '{0, w, m_row, 0, 0, 0, 0};
      q.push_back(e);
      m_row++;
      if (m_row == 16) begin
        m_fd = (m_fd + 1) % 65536;
        e = '{1, 32'h0, 0, m_col, m_frm, m_fd, m_err};
        q.push_back(e);
        m_mode = 1;
      end
    end
  endfunction
  always begin
    ev_t e;
    @(posedge CLK);
    #1;
    if (!reset) begin
      chk("rowwe_onehot", 64'($onehot0(RowWE)), 64'd1);
      chk("strobe_onehot", 64'($onehot0(FrameStrobe)), 64'd1);
      chk("rowwe_strobe_overlap", 64'(RowWE != 0 && FrameStrobe != 0), 64'd0);
      if (FrameStrobe == 0) chk("colsel_idle", 64'(ColSelect), 64'd0);
      if (RowWE != 0) begin
        if (q.size() == 0 || q[0].strb) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_row: got RowWE %0h expected none", RowWE);
        end else begin
          e = q.pop_front();
          chk("rowwe", 64'(RowWE), 64'(16'(1) << e.idx));
          chk("framedata", 64'(FrameData), 64'(e.data));
          if (e.idx == 15) chk("ready_strobe_cycle", 64'(bus.in_ready), 64'd0);
          exp_fd = e.data;
        end
      end else chk("framedata_hold", 64'(FrameData), 64'(exp_fd));
      if (FrameStrobe != 0) begin
        if (q.size() == 0 || !q[0].strb) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_strobe: got FrameStrobe %0h expected none", FrameStrobe);
        end else begin
          e = q.pop_front();
          chk("framestrobe", 64'(FrameStrobe), 64'(20'(1) << e.frm));
          chk("colselect", 64'(ColSelect), 64'(e.col));
          chk("frames_done", 64'(frames_done), 64'(e.fd));
          chk("err_at_strobe", 64'(err), 64'(e.er));
          chk("ready_gap_cycle", 64'(bus.in_ready), 64'd0);
        end
      end
    end
  end
  task automatic send(input logic [31:0] w, input int stall_pct);
    int n = 0;
    while (int'($urandom_range(0, 99)) < stall_pct) begin
      bus.in_valid = 1'b0;
      bus.in_data = $urandom;
      @(negedge CLK);
    end
    bus.in_valid = 1'b1;
    bus.in_data = w;
    while (!bus.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end else model(w);
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask
  task automatic frame(input logic [31:0] hdr, input logic [31:0] base, input int stall_pct);
    send(hdr, 0);
    for (int k = 0; k < 16; k++) send(base + 32'(k), stall_pct);
  endtask
  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    m_mode = 0;
    m_fd = 0;
    m_err = 0;
    exp_fd = '0;
    @(negedge CLK);
    chk("rst_framedata", 64'(FrameData), 64'd0);
    chk("rst_rowwe", 64'(RowWE), 64'd0);
    chk("rst_colselect", 64'(ColSelect), 64'd0);
    chk("rst_framestrobe", 64'(FrameStrobe), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_frames_done", 64'(frames_done), 64'd0);
    reset = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    logic [31:0] h;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) @(negedge CLK);
    do_reset();
    send(32'hFFFF_FFFF, 0);
    chk("junk1_active", 64'(active), 64'd0);
    chk("junk1_ready", 64'(bus.in_ready), 64'd1);
    send(32'h0000_0000, 0);
    chk("junk2_active", 64'(active), 64'd0);
    chk("junk2_ready", 64'(bus.in_ready), 64'd1);
    send(SYNC, 0);
    chk("sync_active", 64'(active), 64'd1);
    frame(32'h0300_0000, 32'h1000_0000, 0);
    frame(32'h0513_0000, 32'h2000_0000, 0);
    repeat (3) @(negedge CLK);
    chk("hdr_wait_active", 64'(active), 64'd1);
    send(32'h0000_8000, 0);
    chk("desync_active", 64'(active), 64'd0);
    send(SYNC, 0);
    send(32'h0014_0000, 0);
    chk("badhdr_err", 64'(err), 64'd1);
    chk("badhdr_active", 64'(active), 64'd0);
    send(32'h0300_0000, 0);
    for (int k = 0; k < 4; k++) send($urandom & 32'h7FFF_FFFF, 0);
    chk("ignored_active", 64'(active), 64'd0);
    send(SYNC, 0);
    frame(32'h0107_0000, 32'h3000_0000, 0);
    chk("err_sticky", 64'(err), 64'd1);
    frame(32'h0A0B_0000, $urandom, 50);
    send(32'h0702_0000, 0);
    for (int k = 0; k < 7; k++) send(32'h4000_0000 + 32'(k), 0);
    do_reset();
    for (int k = 7; k < 16; k++) send(32'h4000_0000 + 32'(k), 0);
    send(32'h0702_0000, 0);
    chk("post_reset_active", 64'(active), 64'd0);
    send(SYNC, 0);
    frame(32'h0702_0000, 32'h5000_0000, 20);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) send(SYNC, 0);
      if (m_mode == 0) send(SYNC, 30);
      h = $urandom;
      h[23:16] = 8'($urandom_range(0, 23));
      h[15] = ($urandom_range(0, 9) == 0);
      send(h, 30);
      for (int k = 0; k < 16; k++) send($urandom, 30);
    end
    repeat (25) @(negedge CLK);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/frame_config_sequencer.md
Name: frame_config_sequencer

Overview:
- Upstream stage of the fabric configuration chain; turns a 32-bit bitstream word stream into per-row frame data loads plus one column-addressed, one-hot FrameStrobe pulse per frame.
- Its row data (FrameData) and FrameStrobe outputs feed the per-row frame data registers and per-column strobe buffers, which then drive every tile's ConfigMem.
- Parses a sync word, then repeated frame headers, each followed by one data word per row. After the last row it fires the strobe.

Parameters:
- FrameBitsPerRow, 32, width of one frame data word (one word per row).
- MaxFramesPerCol, 20, frames per column; width of FrameStrobe.
- NumberOfRows, 16, data words per frame; width of RowWE.
- ColSelWidth, 5, width of ColSelect.
- SyncWord, 32'hFAB0_FAB1, stream synchronisation word.

Ports:
- CLK  in  1  configuration clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  FrameBitsPerRow  bitstream word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts in_data this cycle.
- FrameData  out  FrameBitsPerRow  row data word, valid while any RowWE bit is high.
- RowWE  out  NumberOfRows  one-hot row load pulse.
- ColSelect  out  ColSelWidth  target column, valid while FrameStrobe is non-zero.
- FrameStrobe  out  MaxFramesPerCol  one-hot frame strobe pulse.
- active  out  1  high in every state except IDLE.
- err  out  1  sticky bad-header flag.
- frames_done  out  16  count of strobed frames.

Behaviour:
- Handshake and reset
  - A word transfers when in_valid and in_ready are both high.
  - in_ready is high in IDLE, HDR and DATA; low in STROBE and GAP.
  - Reset value of every output is 0, and state returns to IDLE.
  - Reset mid-frame discards the partial frame: no strobe, and frames_done and err are cleared.
- All outputs are registered. A word accepted in cycle t produces its effect in cycle t+1.
- States:
  - IDLE: an accepted word equal to SyncWord goes to HDR; any other word is discarded.
  - HDR: the accepted word is a header.
    - bit[15]=1 is desync: go to IDLE.
    - Otherwise latch col=in_data[31:24] (low ColSelWidth bits used) and frame=in_data[23:16].
    - If frame >= MaxFramesPerCol, set err and go to IDLE.
    - Otherwise clear row_cnt and go to DATA.
  - DATA: accepted word k (k = row_cnt) drives FrameData=word and RowWE=1<<k in the next cycle, for exactly one cycle. row_cnt then increments.
    - On k = NumberOfRows-1, go to STROBE.
    - in_valid low stalls DATA indefinitely. RowWE stays 0 and FrameData holds its last value.
  - STROBE: for one cycle, FrameStrobe=1<<frame, ColSelect=col, and frames_done increments (wraps at 16'hFFFF→0). Then go to GAP.
    - The strobe cycle immediately follows the last RowWE cycle; the two never overlap.
  - GAP: one cycle with all strobes and RowWE at 0, ColSelect at 0. Then go to HDR.
- Invariants:
  - RowWE and FrameStrobe are at most one-hot.
  - RowWE is never non-zero in the same cycle as FrameStrobe.
  - ColSelect is 0 except during the strobe cycle.
- err stays set until reset. It does not block the next SyncWord.
- active=0 only in IDLE.
- A SyncWord value received in HDR or DATA has no special meaning: it is treated as a header or data.
- Minimum frame time with in_valid held high: 1 header + NumberOfRows data + 2 cycles.

Test Plan:
- Basic frame: reset, send FAB0_FAB1, header 0x0300_0000, then 16 words 0x1000_0000+k.
  - Each word produces RowWE=1<<k with FrameData=0x1000_0000+k one cycle after acceptance.
  - Then one cycle with FrameStrobe=0x00001 and ColSelect=3.
  - frames_done=1, in_ready=0 for 2 cycles.
- Back-to-back frames: after frame 1, send header 0x0513_0000 and 16 words without resync.
  - FrameStrobe=1<<19 and ColSelect=5. frames_done=2.
  - Then header 0x0000_8000: active drops to 0.
- Bad header: frame=20 (0x0014_0000) → err=1, state IDLE, no RowWE or strobe.
  - Following words are ignored until FAB0_FAB1. A valid frame after resync then completes with err still 1.
- Stall: toggle in_valid randomly in DATA → exactly 16 RowWE pulses in order 0..15, and no strobe before the 16th.
- Reset mid-frame: assert reset after 7 data words → all outputs 0 the next cycle, no FrameStrobe ever.
  - Stream restarts only after FAB0_FAB1.
- Preamble junk: send 0xFFFF_FFFF and 0x0000_0000 before sync → discarded, active=0 until sync, in_ready=1 throughout.
